mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high; clock clk.
REQ-003 ex_mem_alu_result  in  32  effective address for load/store, or ALU result.
REQ-004 ex_mem_rs2_data  in  32  store data; ex_mem_pc_4 in 32 return address for JAL/JALR.
REQ-005 ex_mem_rd in 5, ex_mem_funct3 in 3, ex_mem_reg_write_en in 1, ex_mem_mem_read_en in 1, ex_mem_mem_write_en in 1, ex_mem_mem_to_reg_sel in 2: EX/MEM register fields.
REQ-006 dmem_req  out  1  data-memory request; dmem_we out 1 (1 = store); dmem_addr out 32, word-aligned ({addr[31:2],2'b00}).
REQ-007 dmem_wdata  out  32  lane-replicated store data; dmem_wstrb out 4 byte enables.
REQ-008 dmem_ready  in  1  completes the request in the same cycle; dmem_rdata in 32 is valid when dmem_ready=1 on a read.
REQ-009 mem_stall  out  1  upstream stages hold EX/MEM contents stable while high.
REQ-010 mem_wb_rd out 5, mem_wb_reg_write_en out 1, mem_wb_write_data out 32: registered MEM/WB fields, also the forwarding source for EX.
REQ-011 misaligned_err  out  1  and  bus_err  out 1: registered one-cycle exception pulses.

Function
REQ-012 A memory op is present when read_en or write_en =1; read_en takes priority if both are set.
REQ-013 Misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0 -> no dmem_req; misaligned_err pulses next cycle; write-back suppressed; no stall.
REQ-014 dmem_req=1 combinationally for an aligned memory op in state IDLE or WAIT, and is forced to 0 while rst=1.
REQ-015 FSM IDLE: if dmem_req & ~dmem_ready -> WAIT. WAIT: dmem_ready -> IDLE. Timeout -> IDLE.
REQ-016 Zero-wait: dmem_ready=1 in the request cycle completes with no stall and no WAIT entry.
REQ-017 mem_stall = dmem_req & ~dmem_ready.
REQ-018 Wait counter, 4 bits: clears in IDLE, increments each cycle in WAIT. When it reaches TIMEOUT=15 without ready: drop req, return to IDLE, pulse bus_err, suppress write-back, deassert mem_stall that cycle.
REQ-019 Store lanes: SB -> wstrb=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}. SH -> wstrb=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}. SW -> 4'b1111, rs2.
REQ-020 Load extract by addr[1:0]: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. Other funct3 values give 0 with reg_write suppressed.
REQ-021 Write data select: sel 00 = alu_result; 01 = extracted load data; 10 = pc_4; 11 = alu_result.
REQ-022 MEM/WB register loads every cycle. While mem_stall=1 it loads a bubble (reg_write_en=0, rd=0, data=0).
REQ-023 Latency: a non-memory op reaches MEM/WB 1 cycle after presentation; a memory op reaches MEM/WB on the edge after the dmem_ready cycle.
REQ-024 mem_wb_reg_write_en is forced to 0 when rd=0.

Reset
REQ-025 On rst: state=IDLE, counter=0, all MEM/WB outputs 0, misaligned_err=0, bus_err=0.
REQ-026 Reset during WAIT abandons the access: dmem_req=0 in the reset cycle and no write-back afterwards; a late dmem_ready is ignored.

Structure
REQ-027 Shared package riscv_pkg holds: opcode constants, load/store funct3 encodings, mem_to_reg_sel encodings, the state enum, and TIMEOUT.
REQ-028 Lane logic (strobe, replication, extract/extend) lives in sub-module load_store_align, purely combinational.

Verification
REQ-029 LW, addr 0x100, dmem_ready held low 3 cycles -> mem_stall high 3 cycles, 3 bubbles, then mem_wb_write_data=dmem_rdata.
REQ-030 LB, addr 0x103, rdata 0x80FF_FF7F -> write data 0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
REQ-031 SH, addr 0x202, rs2 0x1234_ABCD -> dmem_addr 0x200, wstrb 4'b1100, wdata 0xABCD_ABCD, zero-wait, no stall.
REQ-032 LW, addr 0x101 -> no dmem_req, misaligned_err pulses 1 cycle, mem_wb_reg_write_en=0.
REQ-033 Read, ready never asserted -> bus_err pulses after 15 WAIT cycles, stall released, no write-back.
REQ-034 rst asserted in 2nd WAIT cycle -> dmem_req=0 in that cycle, all outputs 0, ready one cycle later produces no write-back.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and types for the pipeline: opcodes, load/store
// funct3 encodings, write-back selects, the memory-stage FSM state and its timeout.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] WB_SEL_ALU     = 2'b00;
   localparam logic [1:0] WB_SEL_MEM     = 2'b01;
   localparam logic [1:0] WB_SEL_PC4     = 2'b10;
   localparam logic [1:0] WB_SEL_ALU_ALT = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   localparam logic [3:0] TIMEOUT = 4'd15;

   // Store encodings alias the load ones, so SH/SW are covered by the LH/LW items.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3)
         F3_LH, F3_LHU: return addr_lo[0];
         F3_LW:         return |addr_lo;
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave);
// a request completes in any cycle where dmem_ready is high.
interface mem_stage_if;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ready, dmem_rdata
   );

endinterface

// File: rtl/load_store_align.sv
// Byte-lane logic for the MEM stage: store strobes and data replication,
// load byte/half extraction with sign or zero extension. Purely combinational.
module load_store_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        load_valid
);

   logic [15:0] shifted;

   // Addressed byte/half moved down to bit 0; only the low 16 bits are ever needed.
   assign shifted = 16'(load_word >> {addr_lo, 3'b000});

   always_comb begin
      // NOTE: every output gets a default first so this block never infers a latch.
      wstrb = 4'b0000;
      wdata = 32'h0;
      case (funct3)
         F3_SB: begin
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         F3_SH: begin
            wstrb = 4'b0011 << addr_lo;
            wdata = {2{store_data[15:0]}};
         end
         F3_SW: begin
            wstrb = 4'b1111;
            wdata = store_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      load_data  = 32'h0;
      load_valid = 1'b1;
      case (funct3)
         F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU:  load_data = {24'h0, shifted[7:0]};
         F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LHU:  load_data = {16'h0, shifted[15:0]};
         F3_LW:   load_data = load_word;
         default: load_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM pipeline stage: issues loads/stores on the data bus, stalls on wait
// states with a bounded timeout, and registers the MEM/WB write-back fields.
module mem_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ex_mem_alu_result,
   input  logic [31:0] ex_mem_rs2_data,
   input  logic [31:0] ex_mem_pc_4,
   input  logic [4:0]  ex_mem_rd,
   input  logic [2:0]  ex_mem_funct3,
   input  logic        ex_mem_reg_write_en,
   input  logic        ex_mem_mem_read_en,
   input  logic        ex_mem_mem_write_en,
   input  logic [1:0]  ex_mem_mem_to_reg_sel,
   mem_stage_if.master dmem,
   output logic        mem_stall,
   output logic [4:0]  mem_wb_rd,
   output logic        mem_wb_reg_write_en,
   output logic [31:0] mem_wb_write_data,
   output logic        misaligned_err,
   output logic        bus_err
);

   mem_state_e  state;
   logic [3:0]  wait_cnt;

   logic        mem_op;
   logic        misaligned;
   logic        timeout;
   logic [3:0]  lane_wstrb;
   logic [31:0] load_data;
   logic        load_valid;
   logic [31:0] wb_data;
   logic        wb_en;
   logic        bubble;

   assign mem_op     = ex_mem_mem_read_en | ex_mem_mem_write_en;
   assign misaligned = mem_op & is_misaligned(ex_mem_funct3, ex_mem_alu_result[1:0]);
   assign timeout    = (state == ST_WAIT) && (wait_cnt == TIMEOUT) && !dmem.dmem_ready;

   // Reads win when both enables are set, so a store only happens with read_en low.
   assign dmem.dmem_req   = mem_op & ~misaligned & ~timeout & ~rst;
   assign dmem.dmem_we    = ex_mem_mem_write_en & ~ex_mem_mem_read_en;
   assign dmem.dmem_addr  = {ex_mem_alu_result[31:2], 2'b00};
   assign dmem.dmem_wstrb = dmem.dmem_we ? lane_wstrb : 4'b0000;

   assign mem_stall = dmem.dmem_req & ~dmem.dmem_ready;

   load_store_align u_align (
      .funct3     (ex_mem_funct3),
      .addr_lo    (ex_mem_alu_result[1:0]),
      .store_data (ex_mem_rs2_data),
      .load_word  (dmem.dmem_rdata),
      .wstrb      (lane_wstrb),
      .wdata      (dmem.dmem_wdata),
      .load_data  (load_data),
      .load_valid (load_valid)
   );

   always_comb begin
      wb_data = ex_mem_alu_result;
      case (ex_mem_mem_to_reg_sel)
         WB_SEL_MEM: wb_data = load_data;
         WB_SEL_PC4: wb_data = ex_mem_pc_4;
         default:    ;
      endcase
   end

   // x0 is never written, and a load with an unknown width writes nothing.
   assign wb_en  = ex_mem_reg_write_en && (ex_mem_rd != 5'd0)
                   && !(ex_mem_mem_read_en && !load_valid);
   assign bubble = mem_stall | misaligned | timeout;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (rst) begin
         state          <= ST_IDLE;
         wait_cnt       <= 4'd0;
         misaligned_err <= 1'b0;
         bus_err        <= 1'b0;
      end else begin
         misaligned_err <= misaligned;
         bus_err        <= timeout;
         case (state)
            ST_IDLE: begin
               wait_cnt <= 4'd0;
               if (dmem.dmem_req && !dmem.dmem_ready) state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A dropped request (timeout) also ends the wait.
               if (dmem.dmem_ready || !dmem.dmem_req) begin
                  state    <= ST_IDLE;
                  wait_cnt <= 4'd0;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               wait_cnt <= 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         mem_wb_rd           <= 5'd0;
         mem_wb_reg_write_en <= 1'b0;
         mem_wb_write_data   <= 32'h0;
      end else begin
         mem_wb_rd           <= ex_mem_rd;
         mem_wb_reg_write_en <= wb_en;
         mem_wb_write_data   <= wb_data;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs and stores,
// negedge monitors pop and compare whenever the DUT presents one.
module tb_mem_stage;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] alu;
   logic [31:0] rs2;
   logic [31:0] pc4;
   logic [4:0]  rd;
   logic [2:0]  f3;
   logic        rw;
   logic        rd_en;
   logic        wr_en;
   logic [1:0]  sel;
   logic        mem_stall;
   logic [4:0]  wb_rd;
   logic        wb_en;
   logic [31:0] wb_data;
   logic        mis_err;
   logic        bus_err;

   mem_stage_if mem_bus ();

   mem_stage dut (
      .clk                   (clk),
      .rst                   (rst),
      .ex_mem_alu_result     (alu),
      .ex_mem_rs2_data       (rs2),
      .ex_mem_pc_4           (pc4),
      .ex_mem_rd             (rd),
      .ex_mem_funct3         (f3),
      .ex_mem_reg_write_en   (rw),
      .ex_mem_mem_read_en    (rd_en),
      .ex_mem_mem_write_en   (wr_en),
      .ex_mem_mem_to_reg_sel (sel),
      .dmem                  (mem_bus),
      .mem_stall             (mem_stall),
      .mem_wb_rd             (wb_rd),
      .mem_wb_reg_write_en   (wb_en),
      .mem_wb_write_data     (wb_data),
      .misaligned_err        (mis_err),
      .bus_err               (bus_err)
   );

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } st_t;

   wb_t wb_q[$];
   st_t st_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  stalls;

   // Loads against rdata 0x80FF_FF7F, zero-wait.
   logic [2:0]  ld_f3   [6] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LB, F3_LW};
   logic [31:0] ld_addr [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100, 32'h104};
   logic [4:0]  ld_rd   [6] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
   logic [31:0] ld_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_FF7F, 32'h0000_007F, 32'h80FF_FF7F};

   // Stores: funct3, byte address, rs2 -> word address, strobe, bus data.
   logic [2:0]  st_f3   [4] = '{F3_SH, F3_SB, F3_SW, F3_SB};
   logic [31:0] st_a    [4] = '{32'h202, 32'h201, 32'h204, 32'h203};
   logic [31:0] st_d    [4] = '{32'h1234_ABCD, 32'h0000_00EF, 32'h0102_0304, 32'h0000_005A};
   logic [31:0] st_ea   [4] = '{32'h200, 32'h200, 32'h204, 32'h200};
   logic [3:0]  st_es   [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
   logic [31:0] st_ed   [4] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'h0102_0304, 32'h5A5A_5A5A};

   // Misaligned accesses: funct3, read, write, address.
   logic [2:0]  mis_f3  [4] = '{F3_LW, F3_LH, F3_SW, F3_SH};
   logic        mis_rd  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [31:0] mis_a   [4] = '{32'h101, 32'h301, 32'h102, 32'h203};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, expected $finish before 20000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic [2:0] funct3, input logic r_en, input logic w_en,
                        input logic [1:0] s, input logic we_reg, input logic [4:0] dst,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
      f3 = funct3; rd_en = r_en; wr_en = w_en; sel = s; rw = we_reg;
      rd = dst; alu = a; rs2 = d; pc4 = p;
   endtask

   task automatic nop();
      drive(3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      wb_t e;
      if (wb_en) begin
         if (wb_q.size() == 0) begin
            n_checks++;
            $display("FAIL wb_spurious: got rd=%0d data=0x%08h, expected no write-back", wb_rd, wb_data);
         end else begin
            e = wb_q.pop_front();
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_data", wb_data, e.data);
         end
      end
   end

   always @(negedge clk) begin
      st_t e;
      if (mem_bus.dmem_req && mem_bus.dmem_we && mem_bus.dmem_ready) begin
         if (st_q.size() == 0) begin
            n_checks++;
            $display("FAIL store_spurious: got addr=0x%08h strb=%b, expected no store",
                     mem_bus.dmem_addr, mem_bus.dmem_wstrb);
         end else begin
            e = st_q.pop_front();
            check("store_addr", mem_bus.dmem_addr, e.addr);
            check("store_strb", 32'(mem_bus.dmem_wstrb), 32'(e.strb));
            check("store_wdata", mem_bus.dmem_wdata, e.data);
         end
      end
   end

   initial begin
      rst = 1'b1;
      nop();
      mem_bus.dmem_ready = 1'b0;
      mem_bus.dmem_rdata = 32'h0;
      repeat (2) next_cycle();
      @(negedge clk);
      check("rst_wb_en", 32'(wb_en), 32'h0);
      check("rst_wb_rd", 32'(wb_rd), 32'h0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_errs", 32'({mis_err, bus_err}), 32'h0);
      next_cycle();
      rst = 1'b0;

      // Non-memory ops: one-cycle latency, each write-back select, rd=0 suppressed.
      drive(F3_LB, 1'b0, 1'b0, WB_SEL_ALU, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0);
      wb_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
      @(negedge clk);
      check("alu_no_stall", 32'(mem_stall), 32'h0);
      check("alu_no_req", 32'(mem_bus.dmem_req), 32'h0);
      next_cycle();
      drive(F3_LB, 1'b0, 1'b0, WB_SEL_PC4, 1'b1, 5'd1, 32'h999, 32'h0, 32'h1004);
      wb_q.push_back('{rd: 5'd1, data: 32'h1004});
      next_cycle();
      drive(F3_LB, 1'b0, 1'b0, WB_SEL_ALU_ALT, 1'b1, 5'd7, 32'h55, 32'h0, 32'h1008);
      wb_q.push_back('{rd: 5'd7, data: 32'h55});
      next_cycle();
      drive(F3_LB, 1'b0, 1'b0, WB_SEL_ALU, 1'b1, 5'd0, 32'h77, 32'h0, 32'h0);
      next_cycle();
      nop();
      next_cycle();

      // LW with three wait states: three stalls and bubbles, then the loaded word.
      drive(F3_LW, 1'b1, 1'b0, WB_SEL_MEM, 1'b1, 5'd10, 32'h100, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("lw_wait_stall", 32'(mem_stall), 32'h1);
         check("lw_wait_addr", mem_bus.dmem_addr, 32'h100);
         check("lw_wait_bubble", 32'(wb_en), 32'h0);
         next_cycle();
      end
      mem_bus.dmem_ready = 1'b1;
      mem_bus.dmem_rdata = 32'hCAFE_F00D;
      wb_q.push_back('{rd: 5'd10, data: 32'hCAFE_F00D});
      @(negedge clk);
      check("lw_ready_no_stall", 32'(mem_stall), 32'h0);
      next_cycle();

      // Zero-wait loads: lane extraction with sign and zero extension.
      mem_bus.dmem_rdata = 32'h80FF_FF7F;
      for (int i = 0; i < 6; i++) begin
         drive(ld_f3[i], 1'b1, 1'b0, WB_SEL_MEM, 1'b1, ld_rd[i], ld_addr[i], 32'h0, 32'h0);
         wb_q.push_back('{rd: ld_rd[i], data: ld_exp[i]});
         @(negedge clk);
         check("load_zero_wait_stall", 32'(mem_stall), 32'h0);
         next_cycle();
      end
      // Unknown load width: no write-back.
      drive(3'b011, 1'b1, 1'b0, WB_SEL_MEM, 1'b1, 5'd17, 32'h100, 32'h0, 32'h0);
      next_cycle();
      // Read and write both set: the read wins.
      drive(F3_LW, 1'b1, 1'b1, WB_SEL_MEM, 1'b1, 5'd18, 32'h108, 32'h1111_1111, 32'h0);
      wb_q.push_back('{rd: 5'd18, data: 32'h80FF_FF7F});
      @(negedge clk);
      check("rw_both_we", 32'(mem_bus.dmem_we), 32'h0);
      next_cycle();

      // Zero-wait stores: strobes and lane replication.
      for (int i = 0; i < 4; i++) begin
         drive(st_f3[i], 1'b0, 1'b1, WB_SEL_ALU, 1'b0, 5'd0, st_a[i], st_d[i], 32'h0);
         st_q.push_back('{addr: st_ea[i], strb: st_es[i], data: st_ed[i]});
         @(negedge clk);
         check("store_req", 32'(mem_bus.dmem_req), 32'h1);
         check("store_no_stall", 32'(mem_stall), 32'h0);
         next_cycle();
      end

      // Misaligned accesses: no request, one-cycle error pulse, no write-back.
      for (int i = 0; i < 4; i++) begin
         drive(mis_f3[i], mis_rd[i], !mis_rd[i], WB_SEL_MEM, mis_rd[i], 5'd20, mis_a[i],
               32'h0BAD_0BAD, 32'h0);
         @(negedge clk);
         check("mis_no_req", 32'(mem_bus.dmem_req), 32'h0);
         check("mis_no_stall", 32'(mem_stall), 32'h0);
         next_cycle();
         nop();
         @(negedge clk);
         check("mis_err_pulse", 32'(mis_err), 32'h1);
         check("mis_wb_en", 32'(wb_en), 32'h0);
         next_cycle();
         @(negedge clk);
         check("mis_err_clear", 32'(mis_err), 32'h0);
         next_cycle();
      end
      mem_bus.dmem_ready = 1'b0;

      // Timeout: request cycle plus 15 WAIT cycles stall, the 16th WAIT cycle drops req.
      drive(F3_LW, 1'b1, 1'b0, WB_SEL_MEM, 1'b1, 5'd22, 32'h300, 32'h0, 32'h0);
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!mem_stall) break;
         stalls++;
         next_cycle();
      end
      check("timeout_stall_cycles", stalls, 32'd16);
      check("timeout_req_dropped", 32'(mem_bus.dmem_req), 32'h0);
      next_cycle();
      nop();
      @(negedge clk);
      check("bus_err_pulse", 32'(bus_err), 32'h1);
      check("timeout_wb_en", 32'(wb_en), 32'h0);
      next_cycle();
      @(negedge clk);
      check("bus_err_clear", 32'(bus_err), 32'h0);
      next_cycle();

      // Reset in the second WAIT cycle abandons the access; a late ready is ignored.
      drive(F3_LW, 1'b1, 1'b0, WB_SEL_MEM, 1'b1, 5'd23, 32'h400, 32'h0, 32'h0);
      @(negedge clk);
      check("rstwait_stall_req", 32'(mem_stall), 32'h1);
      next_cycle();
      @(negedge clk);
      check("rstwait_stall_w1", 32'(mem_stall), 32'h1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rstwait_req", 32'(mem_bus.dmem_req), 32'h0);
      check("rstwait_stall", 32'(mem_stall), 32'h0);
      next_cycle();
      rst = 1'b0;
      nop();
      mem_bus.dmem_ready = 1'b1;
      mem_bus.dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      check("rstwait_wb_en", 32'(wb_en), 32'h0);
      check("rstwait_wb_rd", 32'(wb_rd), 32'h0);
      check("rstwait_wb_data", wb_data, 32'h0);
      check("rstwait_errs", 32'({mis_err, bus_err}), 32'h0);
      next_cycle();
      mem_bus.dmem_ready = 1'b0;
      @(negedge clk);
      check("rstwait_no_wb", 32'(wb_en), 32'h0);
      next_cycle();

      drive(F3_LB, 1'b0, 1'b0, WB_SEL_ALU, 1'b1, 5'd9, 32'hA5A5_A5A5, 32'h0, 32'h0);
      wb_q.push_back('{rd: 5'd9, data: 32'hA5A5_A5A5});
      next_cycle();
      nop();
      repeat (2) next_cycle();

      check("wb_queue_drained", wb_q.size(), 32'h0);
      check("st_queue_drained", st_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
